// File: rtl/interp_mv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : interp_mv_ctrl
//  Purpose  : Per-block sequencer for the fractional interpolation datapath.
//             Accepts a packed MV and writes it to the MV register. Decodes
//             the quarter-pel phases, then steps rows through the integer
//             copy pass, the horizontal pass and/or the vertical pass.
//  Options  : define INTERP_PERF_CNT_EN to add the PERF_STALLS stall counter
//  Revision : 1.0  initial release
// ============================================================================
module interp_mv_ctrl #(
  parameter int BLOCK_H = 8,
  parameter int TAPS    = 8
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                START,
  input  logic [7:0]                          MV_IN,
  input  logic                                ROW_READY,
  output logic                                READY,
  output logic                                MV_WE,
  output logic [7:0]                          MV_DATA,
  output logic [1:0]                          H_FRAC,
  output logic [1:0]                          V_FRAC,
  output logic                                COPY_EN,
  output logic                                H_EN,
  output logic                                V_EN,
  output logic                                ROW_VALID,
  output logic [$clog2(BLOCK_H+TAPS)-1:0]     ROW_IDX,
  output logic                                DONE
`ifdef INTERP_PERF_CNT_EN
  ,
  output logic [15:0]                         PERF_STALLS
`endif
);

  localparam int IW = $clog2(BLOCK_H + TAPS);

  // Index of the final row of a pass: short passes cover the block only,
  // the long horizontal pass also produces the vertical filter's margin rows.
  localparam logic [IW-1:0] LAST_SHORT = IW'(BLOCK_H - 1);
  localparam logic [IW-1:0] LAST_LONG  = IW'(BLOCK_H + TAPS - 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_COPY  = 3'd2;
  localparam logic [2:0] S_HPASS = 3'd3;
  localparam logic [2:0] S_VPASS = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    mv_q, mv_d;
  logic [1:0]    hfrac_q, hfrac_d;
  logic [1:0]    vfrac_q, vfrac_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] last_row;
  logic          pass_active;
  logic          last_issue;

  // Last row of the current pass issues this cycle
  always_comb begin
    last_row   = (state_q == S_HPASS && vfrac_q != 2'd0) ? LAST_LONG : LAST_SHORT;
    last_issue = ROW_VALID && (row_q == last_row);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; LOAD decodes straight from the captured MV so the
  // choice of first pass does not wait for the fraction registers
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_LOAD;
      S_LOAD: begin
        if (mv_q[5:4] == 2'd0 && mv_q[1:0] == 2'd0) state_d = S_COPY;
        else if (mv_q[5:4] != 2'd0)                 state_d = S_HPASS;
        else                                        state_d = S_VPASS;
      end
      S_COPY:  if (last_issue) state_d = S_FIN;
      S_HPASS: if (last_issue) state_d = (vfrac_q != 2'd0) ? S_VPASS : S_FIN;
      S_VPASS: if (last_issue) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; MV_DATA shows MV_IN during the accept cycle so the MV
  // register captures the new vector on the same edge as MV_WE
  always_comb begin
    READY       = (state_q == S_IDLE);
    MV_WE       = (state_q == S_IDLE) && START;
    COPY_EN     = (state_q == S_COPY);
    H_EN        = (state_q == S_HPASS);
    V_EN        = (state_q == S_VPASS);
    pass_active = COPY_EN || H_EN || V_EN;
    ROW_VALID   = pass_active && ROW_READY;
    DONE        = (state_q == S_FIN);
    MV_DATA     = MV_WE ? MV_IN : mv_q;
    H_FRAC      = hfrac_q;
    V_FRAC      = vfrac_q;
    ROW_IDX     = row_q;
  end

  // Datapath next values: MV capture, fraction latch, row counter
  always_comb begin
    mv_d    = mv_q;
    hfrac_d = hfrac_q;
    vfrac_d = vfrac_q;
    row_d   = row_q;
    if (MV_WE) mv_d = MV_IN;
    if (state_q == S_LOAD) begin
      hfrac_d = mv_q[5:4];
      vfrac_d = mv_q[1:0];
      row_d   = '0;
    end else if (ROW_VALID) begin
      row_d = last_issue ? '0 : row_q + IW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      mv_q    <= 8'h00;
      hfrac_q <= 2'd0;
      vfrac_q <= 2'd0;
      row_q   <= '0;
    end else begin
      mv_q    <= mv_d;
      hfrac_q <= hfrac_d;
      vfrac_q <= vfrac_d;
      row_q   <= row_d;
    end
  end

`ifdef INTERP_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count of stalled pass cycles, restarted for each block
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_LOAD)
      perf_d = 16'h0000;
    else if (pass_active && !ROW_READY && perf_q != 16'hFFFF)
      perf_d = perf_q + 16'h0001;
  end

  // Stall counter register
  always_ff @(posedge CLK) begin
    if (RST) perf_q <= 16'h0000;
    else     perf_q <= perf_d;
  end

  assign PERF_STALLS = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_interp_mv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interp_mv_ctrl
//  Purpose  : Self-checking bench for interp_mv_ctrl using a pass-list model
//  Revision : 1.0  initial release
// ============================================================================
module tb_interp_mv_ctrl;

  localparam int BLOCK_H = 8;
  localparam int TAPS    = 8;
  localparam int IW      = $clog2(BLOCK_H + TAPS);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [7:0]    MV_IN = 8'h00;
  logic          ROW_READY = 1'b1;
  logic          READY, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE;
  logic [7:0]    MV_DATA;
  logic [1:0]    H_FRAC, V_FRAC;
  logic [IW-1:0] ROW_IDX;
`ifdef INTERP_PERF_CNT_EN
  logic [15:0]   PERF_STALLS;
`endif

  int total = 0;
  int bad   = 0;

  interp_mv_ctrl #(.BLOCK_H(BLOCK_H), .TAPS(TAPS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MV_IN(MV_IN), .ROW_READY(ROW_READY),
    .READY(READY), .MV_WE(MV_WE), .MV_DATA(MV_DATA), .H_FRAC(H_FRAC),
    .V_FRAC(V_FRAC), .COPY_EN(COPY_EN), .H_EN(H_EN), .V_EN(V_EN),
    .ROW_VALID(ROW_VALID), .ROW_IDX(ROW_IDX), .DONE(DONE)
`ifdef INTERP_PERF_CNT_EN
    , .PERF_STALLS(PERF_STALLS)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; ROW_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    total++;
    if (READY !== 1'b1 || {MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE} !== 6'b0 ||
        MV_DATA !== 8'h00 || H_FRAC !== 2'd0 || V_FRAC !== 2'd0 || ROW_IDX !== '0) begin
      bad++;
      $display("FAIL reset: ready=%b we=%b en=%b%b%b rv=%b done=%b mv=%h hf=%0d vf=%0d idx=%0d, want ready=1 rest 0",
               READY, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE, MV_DATA, H_FRAC, V_FRAC, ROW_IDX);
    end
  endtask

  // Runs one block. mode 0: ROW_READY high, 1: random stalls, 2: stalls on
  // cycles 5-7. extra_start: cycle number on which a stray START is driven.
  task automatic test_block(input logic [7:0] mv, input int mode, input int extra_start);
    int   kinds[$];
    int   rows[$];
    int   pi, ri, cyc, stalls;
    bit   fin;
    logic rr, ec, eh, ev;
    logic [1:0] hf, vf;
    logic [IW-1:0] eidx;
    hf = mv[5:4];
    vf = mv[1:0];
    // Pass list derived from the fraction rules
    if (hf == 2'd0 && vf == 2'd0) begin kinds.push_back(0); rows.push_back(BLOCK_H); end
    if (hf != 2'd0) begin kinds.push_back(1); rows.push_back(vf != 2'd0 ? BLOCK_H + TAPS - 1 : BLOCK_H); end
    if (vf != 2'd0) begin kinds.push_back(2); rows.push_back(BLOCK_H); end

    // cycle 0: acceptance
    @(posedge CLK); #1;
    START = 1'b1; MV_IN = mv; ROW_READY = 1'b1;
    @(negedge CLK);
    total++;
    if (MV_WE !== 1'b1 || MV_DATA !== mv || READY !== 1'b1) begin
      bad++;
      $display("FAIL accept mv=%h: we=%b data=%h ready=%b, want 1 %h 1", mv, MV_WE, MV_DATA, READY, mv);
    end
    // cycle 1: LOAD
    @(posedge CLK); #1;
    START = 1'b0; MV_IN = 8'($urandom);
    @(negedge CLK);
    total++;
    if ({READY, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE} !== 7'b0 || MV_DATA !== mv) begin
      bad++;
      $display("FAIL load mv=%h: ready/we/en/rv/done=%b%b%b%b%b%b%b data=%h, want all 0 data %h",
               mv, READY, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE, MV_DATA, mv);
    end

    pi = 0; ri = 0; cyc = 2; stalls = 0; fin = 1'b0;
    while (!fin && cyc < 600) begin
      @(posedge CLK); #1;
      if (mode == 0)      rr = 1'b1;
      else if (mode == 2) rr = !(cyc >= 5 && cyc <= 7);
      else                rr = ($urandom_range(3) != 0);
      ROW_READY = rr;
      START = (cyc == extra_start);
      MV_IN = 8'($urandom);
      @(negedge CLK);
      if (pi < kinds.size()) begin
        ec = (kinds[pi] == 0); eh = (kinds[pi] == 1); ev = (kinds[pi] == 2);
        eidx = ri[IW-1:0];
        total++;
        if (COPY_EN !== ec || H_EN !== eh || V_EN !== ev || ROW_VALID !== rr || ROW_IDX !== eidx ||
            DONE !== 1'b0 || READY !== 1'b0 || MV_WE !== 1'b0 || MV_DATA !== mv ||
            H_FRAC !== hf || V_FRAC !== vf) begin
          bad++;
          $display("FAIL row mv=%h cyc=%0d: en=%b%b%b rv=%b idx=%0d done=%b ready=%b we=%b data=%h hf=%0d vf=%0d, want en=%b%b%b rv=%b idx=%0d hf=%0d vf=%0d",
                   mv, cyc, COPY_EN, H_EN, V_EN, ROW_VALID, ROW_IDX, DONE, READY, MV_WE, MV_DATA,
                   H_FRAC, V_FRAC, ec, eh, ev, rr, eidx, hf, vf);
        end
        if (!rr) stalls++;
        else begin
          ri++;
          if (ri == rows[pi]) begin pi++; ri = 0; end
        end
      end else begin
        total++;
        if (DONE !== 1'b1 || {COPY_EN, H_EN, V_EN, ROW_VALID, READY, MV_WE} !== 6'b0) begin
          bad++;
          $display("FAIL done mv=%h cyc=%0d: done=%b en=%b%b%b rv=%b ready=%b we=%b, want done=1 rest 0",
                   mv, cyc, DONE, COPY_EN, H_EN, V_EN, ROW_VALID, READY, MV_WE);
        end
`ifdef INTERP_PERF_CNT_EN
        total++;
        if (PERF_STALLS !== 16'(stalls)) begin
          bad++;
          $display("FAIL perf mv=%h: got %0d want %0d", mv, PERF_STALLS, stalls);
        end
`endif
        fin = 1'b1;
      end
      cyc++;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout mv=%h: no DONE within cycle budget", mv);
    end
    // following cycle: idle again, no stray block
    @(posedge CLK); #1;
    START = 1'b0; ROW_READY = 1'b1;
    @(negedge CLK);
    total++;
    if (READY !== 1'b1 || {DONE, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID} !== 6'b0) begin
      bad++;
      $display("FAIL post mv=%h: ready=%b done=%b we=%b en=%b%b%b rv=%b, want ready=1 rest 0",
               mv, READY, DONE, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID);
    end
  endtask

  task automatic test_copy();       test_block(8'h00, 0, -1); endtask
  task automatic test_hv();         test_block(8'h11, 0, -1); endtask
  task automatic test_stall();      test_block(8'hF2, 2, -1); endtask
  task automatic test_v_only();     test_block(8'h03, 0, 4);  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(posedge CLK); #1;
    START = 1'b1; MV_IN = 8'h11; ROW_READY = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      if (c == 6) RST = 1'b1;
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if (READY !== 1'b1 || {MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE} !== 6'b0 ||
        MV_DATA !== 8'h00 || H_FRAC !== 2'd0 || V_FRAC !== 2'd0 || ROW_IDX !== '0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b we=%b en=%b%b%b rv=%b done=%b mv=%h hf=%0d vf=%0d idx=%0d, want ready=1 rest 0",
               READY, MV_WE, COPY_EN, H_EN, V_EN, ROW_VALID, DONE, MV_DATA, H_FRAC, V_FRAC, ROW_IDX);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1 || READY !== 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL reset_mid_idle: got done/busy after reset, want idle with no DONE");
    end
    test_block(8'h10, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      test_block(8'($urandom), 1, (n % 2 == 0) ? int'($urandom_range(3, 12)) : -1);
  endtask

  initial begin
    test_reset();
    test_copy();
    test_hv();
    test_stall();
    test_v_only();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interp_mv_ctrl.md
Name: interp_mv_ctrl

Overview:
Per-block sequencer for the fractional interpolation datapath. It accepts a packed motion vector through a start handshake and writes it into the MV register. It decodes the horizontal and vertical fractional phases, then steps the row-wise horizontal pass, vertical pass or integer-copy pass. It signals completion and sits between the prediction-request interface and the MV register, filter and row buffer.

Parameters:
BLOCK_H, 8, output block height in rows (2..64)
TAPS, 8, filter tap count; the horizontal pass emits TAPS-1 extra rows when a vertical pass follows

Ports:
CLK  input  1  clock
RST  input  1  synchronous reset, active-high
START  input  1  request to process one block; sampled only when READY=1
MV_IN  input  8  signed packed MV; [7:4] horizontal, [3:0] vertical; within each nibble, [3:2] integer and [1:0] quarter-pel fraction
ROW_READY  input  1  downstream row buffer can take a row this cycle
READY  output  1  controller idle, START is accepted
MV_WE  output  1  one-cycle write enable to the MV register
MV_DATA  output  8  value written to the MV register (MV_IN captured at acceptance)
H_FRAC  output  2  horizontal fraction, MV[5:4]
V_FRAC  output  2  vertical fraction, MV[1:0]
COPY_EN  output  1  integer-copy pass active
H_EN  output  1  horizontal filter pass active
V_EN  output  1  vertical filter pass active
ROW_VALID  output  1  a row is issued this cycle
ROW_IDX  output  clog2(BLOCK_H+TAPS)  index of the issued row within the current pass
DONE  output  1  one-cycle pulse, block finished

Behaviour:
- Reset values (RST=1 at a clock edge; has priority over everything): state IDLE, READY=1, all other outputs 0, including MV_DATA, fractions and ROW_IDX.
- States: IDLE, LOAD, COPY, HPASS, VPASS, FIN.
- IDLE: READY=1.
  - START=1 -> capture MV_IN into MV_DATA, MV_WE=1 in the same cycle, go to LOAD.
  - START=0 -> stay.
- LOAD, one cycle, READY=0: register H_FRAC=MV_DATA[5:4] and V_FRAC=MV_DATA[1:0]; these hold until the next LOAD. Next state:
  - H_FRAC=0 and V_FRAC=0 -> COPY
  - H_FRAC!=0 -> HPASS
  - otherwise -> VPASS
- Row counts:
  - COPY: BLOCK_H rows.
  - HPASS: BLOCK_H+TAPS-1 rows if V_FRAC!=0, else BLOCK_H.
  - VPASS: BLOCK_H rows.
- Row stepping within any pass:
  - the pass enable (COPY_EN, H_EN or V_EN) stays high for the whole pass, including stall cycles;
  - ROW_VALID = ROW_READY;
  - ROW_IDX starts at 0 and increments only when ROW_VALID=1;
  - ROW_READY=0 stalls with ROW_IDX held.
- Pass exits, on the cycle the last row issues:
  - HPASS -> VPASS if V_FRAC!=0, else FIN;
  - COPY and VPASS -> FIN;
  - ROW_IDX resets to 0 on every pass change.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- Latency with ROW_READY tied high, START accepted at cycle 0: LOAD at 1, rows from cycle 2, DONE at 2+total_rows, READY high the following cycle.
- START while READY=0 is ignored; no queuing. MV_IN is ignored outside acceptance.
- MV_WE never asserts outside IDLE acceptance.
- RST mid-pass: return to IDLE next cycle, no DONE pulse, MV_DATA cleared.
- Sign: the integer part is passed through in MV_DATA only; this block does no arithmetic on it.

Optional Feature:
INTERP_PERF_CNT_EN
- Defined: adds output PERF_STALLS, 16 bits. It counts cycles with a pass enable high and ROW_READY=0, saturating at 16'hFFFF. It clears on RST and on each LOAD.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then START=1 with MV_IN=8'h00, ROW_READY=1 -> MV_WE=1 at cycle 0 with MV_DATA=8'h00; COPY_EN cycles 2-9 with ROW_IDX 0..7; DONE at cycle 10; READY=1 at cycle 11.
- MV_IN=8'h11 (H_FRAC=1, V_FRAC=1), BLOCK_H=8, TAPS=8 -> H_EN for 15 rows (cycles 2-16); V_EN for 8 rows (cycles 17-24); DONE at 25.
- MV_IN=8'hF2 (H_FRAC=3, V_FRAC=2) with ROW_READY=0 at cycles 5-7 -> ROW_IDX frozen at 3 for those cycles; H_EN stays high; completion delayed by exactly 3 cycles (DONE at 28); PERF_STALLS=3 when the macro is enabled.
- MV_IN=8'h03 (V only) -> no H_EN; V_EN 8 rows on cycles 2-9; DONE at 10. A second START during cycle 4 produces no MV_WE and no extra block.
- RST=1 at cycle 6 of an 8'h11 block -> next cycle all outputs 0 and READY=1; no DONE; a subsequent START with 8'h10 runs a clean H-only 8-row pass.
